// File: rtl/bram_pkg.sv
// Shared sizing constants and word/address types for the 4K x 18 block RAM.
package bram_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] bram_addr_t;
  typedef logic [DATA_W-1:0] bram_data_t;

  // Zero-extends an address into a data word (handy for address-tagged fills).
  function automatic bram_data_t addr_to_data(input bram_addr_t addr);
    return DATA_W'(addr);
  endfunction

endpackage

// File: rtl/bram_array.sv
// Raw single-port storage with a synchronous write port and a read-first registered read port.
// Deliberately reset-free so it maps directly onto a block-RAM macro.
module bram_array import bram_pkg::*; #(
  parameter int unsigned AddrW = bram_pkg::ADDR_W,
  parameter int unsigned DataW = bram_pkg::DATA_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

`ifdef SYNTHESIS
  logic [DataW-1:0] mem_q [Depth];
`else
  logic [DataW-1:0] mem_q [Depth] = '{default: '0};
`endif

  logic [DataW-1:0] rdata_q;

  // Read samples the pre-write contents, giving read-first behaviour on a collision.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_4kx18.sv
// 4096 x 18 single-port block RAM with enable-gated commands and a resettable output.
// Define BRAM_OUT_REG_EN to add a second output pipeline stage (read latency 2).
module bram_4kx18 import bram_pkg::*; #(
  parameter int unsigned ADDR_W = bram_pkg::ADDR_W,
  parameter int unsigned DATA_W = bram_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BRAM_EN,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT
);

  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] rdata;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] stage1;

  // Commands seen while reset is low are dropped, writes included.
  always_comb begin
    rd_en = BRAM_EN & READ & RST;
    wr_en = BRAM_EN & WRITE & RST;
  end

  bram_array #(
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (wr_en),
    .re_i    (rd_en),
    .addr_i  (ADDR),
    .wdata_i (DIN),
    .rdata_o (rdata)
  );

  // The array register has no reset; this flag masks it to zero until the first read
  // after reset, so the visible read register clears asynchronously.
  always_comb begin
    valid_d = valid_q | rd_en;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_comb begin
    stage1 = valid_q ? rdata : '0;
  end

`ifdef BRAM_OUT_REG_EN
  logic [DATA_W-1:0] dout2_d, dout2_q;

  always_comb begin
    dout2_d = stage1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout2_q <= '0;
    end else begin
      dout2_q <= dout2_d;
    end
  end

  assign DOUT = dout2_q;
`else
  assign DOUT = stage1;
`endif

endmodule

// File: tb/tb_bram_4kx18.sv
// Scoreboard bench for bram_4kx18: stimulus queues expected read data, a monitor checks DOUT.
module tb_bram_4kx18;
  import bram_pkg::*;

`ifdef BRAM_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic       CLK;
  logic       RST;
  logic       BRAM_EN;
  logic       READ;
  logic       WRITE;
  bram_addr_t ADDR;
  bram_data_t DIN;
  bram_data_t DOUT;

  bram_4kx18 dut (
    .CLK     (CLK),
    .RST     (RST),
    .BRAM_EN (BRAM_EN),
    .READ    (READ),
    .WRITE   (WRITE),
    .ADDR    (ADDR),
    .DIN     (DIN),
    .DOUT    (DOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  bram_data_t exp_q[$];
  logic [1:0] pipe;
  logic       done;
  logic       finished;
  int         checks;
  int         errors;
  bram_data_t hold_val;

  // Tracks which edges accepted a read so the monitor knows when data is due.
  always @(posedge CLK or negedge RST) begin
    if (!RST) pipe <= 2'b00;
    else      pipe <= {pipe[0], BRAM_EN & READ};
  end

  task automatic check(input bram_data_t act, input bram_data_t req, input string name);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: DOUT=%05h expected=%05h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    hold_val = '0;
    finished = 1'b0;
  end

  always @(negedge CLK or negedge RST) begin
    if (!finished) begin
      if (RST !== 1'b1) begin
        #1;
        check(DOUT, '0, "reset_clear");
        hold_val = '0;
      end else if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d expected reads never returned (required 0)", exp_q.size());
        end
        finished = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end else if (pipe[Lat-1]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_data: DOUT=%05h with no expected read queued", DOUT);
        end else begin
          hold_val = exp_q.pop_front();
          check(DOUT, hold_val, "read_data");
        end
      end else begin
        check(DOUT, hold_val, "hold");
      end
    end
  end

  task automatic cmd(input logic en, input logic rd, input logic wr, input bram_addr_t a,
                     input bram_data_t d, input bram_data_t e);
    @(negedge CLK);
    #1;
    BRAM_EN = en;
    READ    = rd;
    WRITE   = wr;
    ADDR    = a;
    DIN     = d;
    if (en && rd && RST) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    done    = 1'b0;
    RST     = 1'b0;
    BRAM_EN = 1'b0;
    READ    = 1'b0;
    WRITE   = 1'b0;
    ADDR    = '0;
    DIN     = '0;
    repeat (2) @(negedge CLK);
    #1;
    RST = 1'b1;
    idle(3);

    // Write both ends of the array, then read them back.
    cmd(1, 0, 1, 12'h000, 18'h2A5A5, '0);
    cmd(1, 0, 1, 12'hFFF, 18'h3FFFF, '0);
    cmd(1, 1, 0, 12'h000, '0, 18'h2A5A5);
    cmd(1, 1, 0, 12'hFFF, '0, 18'h3FFFF);
    idle(3);

    // Read-first collision.
    cmd(1, 0, 1, 12'h010, 18'h00001, '0);
    cmd(1, 1, 1, 12'h010, 18'h00002, 18'h00001);
    cmd(1, 1, 0, 12'h010, '0, 18'h00002);
    idle(3);

    // Enable gating: disabled write and read must change nothing.
    cmd(1, 0, 1, 12'h020, 18'h00777, '0);
    cmd(1, 1, 0, 12'h020, '0, 18'h00777);
    idle(2);
    cmd(0, 0, 1, 12'h020, 18'h12345, '0);
    cmd(0, 1, 0, 12'h020, '0, '0);
    cmd(1, 0, 1, 12'h030, 18'h00555, '0);
    idle(2);
    cmd(1, 1, 0, 12'h020, '0, 18'h00777);
    idle(3);

    // Reset mid-cycle with non-zero DOUT; commands during reset are dropped.
    cmd(1, 0, 1, 12'h100, 18'h0BEEF, '0);
    cmd(1, 1, 0, 12'h100, '0, 18'h0BEEF);
    idle(3);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    cmd(1, 0, 1, 12'h100, 18'h3FFFF, '0);
    cmd(1, 1, 0, 12'h100, '0, '0);
    idle(1);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    idle(2);
    cmd(1, 1, 0, 12'h100, '0, 18'h0BEEF);
    idle(3);

    // Full address-tagged sweep.
    for (int a = 0; a < 4096; a++) begin
      cmd(1, 0, 1, bram_addr_t'(a), addr_to_data(bram_addr_t'(a)), '0);
    end
    for (int a = 0; a < 4096; a++) begin
      cmd(1, 1, 0, bram_addr_t'(a), '0, addr_to_data(bram_addr_t'(a)));
    end
    idle(4);
    done = 1'b1;
  end

endmodule
